// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - shares one pixel RAM between VGA scan-out and a FIFO-buffered pixel writer
module vga_fb_arbiter #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int ADDR_W   = 19,
    parameter int PIX_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              frame_start,
    input  logic              pre_de,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_drop,
    output logic [2:0]        fifo_level,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  rgb_out,
    output logic              de_out
);

    localparam int NPIX = H_ACTIVE * V_ACTIVE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN
    } mode_t;

    mode_t             mode;
    logic [ADDR_W-1:0] fifo_addr [4];
    logic [PIX_W-1:0]  fifo_data [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] scan_addr;
    logic              de_q;
    logic              in_range;
    logic              xfer;
    logic              push;
    logic              pop;

    assign in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(NPIX));
    assign wr_ready = (fifo_level < 3'd4) & ~rst;
    assign xfer     = wr_valid & wr_ready;
    assign push     = xfer & in_range;
    assign pop      = (mode == ST_DRAIN) & ~rst;

    // Scan-out always wins while the display is live; the FIFO only drains otherwise.
    always_comb begin
        mode      = ST_IDLE;
        scan_addr = frame_start ? '0 : rd_addr;
        mem_addr  = rd_addr;
        mem_we    = 1'b0;
        mem_wdata = fifo_data[rd_ptr];
        if (pre_de && en) begin
            mode = ST_SCAN;
        end else if (fifo_level != 3'd0) begin
            mode = ST_DRAIN;
        end
        case (mode)
            ST_SCAN:  mem_addr = scan_addr;
            ST_DRAIN: begin
                mem_addr = fifo_addr[rd_ptr];
                mem_we   = ~rst;
            end
            default:  mem_addr = rd_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr;
            fifo_data[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            de_q       <= 1'b0;
            de_out     <= 1'b0;
            rgb_out    <= '0;
            wr_drop    <= 1'b0;
        end else begin
            if (mode == ST_SCAN) begin
                rd_addr <= (scan_addr == LAST_ADDR) ? '0 : scan_addr + 1'b1;
            end else if (frame_start) begin
                rd_addr <= '0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            fifo_level <= fifo_level + {2'b0, push} - {2'b0, pop};
            wr_drop    <= xfer & ~in_range;
            // Two-stage read pipeline: address cycle, RAM latency, then output register.
            de_q       <= (mode == ST_SCAN);
            de_out     <= de_q & en;
            rgb_out    <= (de_q & en) ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - randomized scoreboard bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int N  = H * V;
    localparam int AW = 19;
    localparam int PW = 3;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int due;
        int val;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          frame_start;
    logic          pre_de;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          wr_drop;
    logic [2:0]    fifo_level;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [PW-1:0] mem_wdata;
    logic [PW-1:0] mem_rdata;
    logic [PW-1:0] rgb_out;
    logic          de_out;

    vga_fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .frame_start(frame_start), .pre_de(pre_de),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_drop(wr_drop), .fifo_level(fifo_level), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rgb_out(rgb_out), .de_out(de_out)
    );

    always #5 clk = ~clk;

    logic [PW-1:0] ram [N];
    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < N) ram[mem_addr] <= mem_wdata;
        mem_rdata <= (int'(mem_addr) < N) ? ram[mem_addr] : '0;
    end

    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    int   pos    = 0;
    int   ref_img [N];
    wr_t  mq [$];
    wr_t  ew [$];
    pix_t pq [$];
    bit   exp_drop = 0;
    bit   exp_drop_n = 0;
    bit   xfer_m = 0;
    bit   running = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: pending writes drain in order on every non-display cycle; pixels appear two cycles after scan.
    task automatic step();
        wr_t e;
        int  idx;
        bit  ready_m;
        #1;
        ready_m = (mq.size() < 4) && !rst;
        chk("wr_ready", wr_ready, ready_m);
        chk("fifo_level", fifo_level, mq.size());
        chk("wr_drop", wr_drop, exp_drop);
        xfer_m = wr_valid && ready_m;
        exp_drop_n = 0;
        if (rst) begin
            chk("mem_we_in_reset", mem_we, 0);
            mq.delete();
            pos = 0;
            while (pq.size() > 0 && pq[pq.size()-1].due > cyc) void'(pq.pop_back());
        end else begin
            if (!en) begin
                while (pq.size() > 0 && pq[pq.size()-1].due == cyc + 1) void'(pq.pop_back());
            end
            if (pre_de && en) begin
                idx = frame_start ? 0 : pos;
                chk("scan_addr", mem_addr, idx);
                chk("mem_we_in_scan", mem_we, 0);
                pq.push_back('{cyc + 2, ref_img[idx]});
                pos = (idx + 1) % N;
            end else begin
                if (frame_start) pos = 0;
                if (mq.size() > 0) begin
                    e = mq.pop_front();
                    ew.push_back(e);
                end else begin
                    chk("mem_we_idle", mem_we, 0);
                end
            end
            if (xfer_m) begin
                if (int'(wr_addr) < N) mq.push_back('{int'(wr_addr), int'(wr_data)});
                else exp_drop_n = 1;
            end
        end
        @(posedge clk);
        cyc++;
        exp_drop = exp_drop_n;
        #1;
    endtask

    always @(negedge clk) begin
        if (running) begin
            if (mem_we) begin
                if (ew.size() == 0) begin
                    chk("unexpected_mem_we", mem_we, 0);
                end else begin
                    wr_t e;
                    e = ew.pop_front();
                    chk("mem_wr_addr", mem_addr, e.addr);
                    chk("mem_wr_data", mem_wdata, e.data);
                    ref_img[e.addr] = e.data;
                end
            end
            if (de_out) begin
                if (pq.size() == 0 || pq[0].due != cyc) begin
                    chk("unexpected_de_out", de_out, 0);
                end else begin
                    pix_t p;
                    p = pq.pop_front();
                    chk("rgb_out", rgb_out, p.val);
                end
            end else begin
                chk("rgb_out_blank", rgb_out, 0);
                if (pq.size() > 0 && pq[0].due == cyc) begin
                    void'(pq.pop_front());
                    chk("missing_de_out", de_out, 1);
                end
            end
        end
    end

    task automatic set_wr(input bit v, input int a, input int d);
        wr_valid = v;
        wr_addr  = AW'(a);
        wr_data  = PW'(d);
    endtask

    initial begin
        int k;
        int blank;
        for (int i = 0; i < N; i++) begin
            ram[i] = '0;
            ref_img[i] = 0;
        end
        rst = 1; en = 1; frame_start = 0; pre_de = 0;
        set_wr(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        running = 1;
        step();
        rst = 0;
        step();

        // Preload pixels 0..3 with 1..4, then scan them out at the start of a frame.
        for (int i = 0; i < 4; i++) begin
            set_wr(1, i, i + 1);
            step();
        end
        set_wr(0, 0, 0);
        repeat (6) step();
        for (int i = 0; i < 4; i++) begin
            pre_de = 1;
            frame_start = (i == 0);
            step();
        end
        frame_start = 0; pre_de = 0;
        repeat (4) step();

        // Writer stalled across an active line; backlog drains in order when blanking starts.
        k = 0;
        pre_de = 1;
        for (int i = 0; i < 20; i++) begin
            set_wr(k < 6, 40 + k, k + 2);
            step();
            if (xfer_m) k++;
        end
        pre_de = 0;
        for (int i = 0; i < 20 && k < 6; i++) begin
            set_wr(1, 40 + k, k + 2);
            step();
            if (xfer_m) k++;
        end
        set_wr(0, 0, 0);
        repeat (6) step();

        // Push while draining at level 2.
        pre_de = 1;
        set_wr(1, 60, 5); step();
        set_wr(1, 61, 6); step();
        pre_de = 0;
        set_wr(1, 62, 7); step();
        set_wr(0, 0, 0);
        repeat (5) step();

        // Out-of-range address is accepted and dropped.
        set_wr(1, N, 3); step();
        set_wr(0, 0, 0);
        repeat (3) step();

        // Reset in the middle of a scan with three queued writes.
        pre_de = 1; frame_start = 1; step();
        frame_start = 0;
        for (int i = 0; i < 3; i++) begin
            set_wr(1, 70 + i, i + 1);
            step();
        end
        set_wr(0, 0, 0);
        rst = 1; step();
        rst = 0;
        repeat (4) step();
        pre_de = 0;
        repeat (4) step();

        // Full frame scan through the last pixel and wrap, then en=0 frees the RAM mid-line.
        pre_de = 1; frame_start = 1; step();
        frame_start = 0;
        for (int i = 0; i < N + 2; i++) begin
            set_wr(i >= N && i < N + 2, 90 + i - N, 6);
            step();
        end
        set_wr(0, 0, 0);
        en = 0;
        repeat (4) step();
        pre_de = 0; en = 1;
        repeat (3) step();

        // Randomized lines with blanking, frame pulses, enable changes and random writes.
        for (int line = 0; line < 24; line++) begin
            blank = 3 + int'($urandom_range(0, 6));
            for (int b = 0; b < blank; b++) begin
                pre_de = 0;
                if (b == 2) en = ($urandom_range(0, 4) != 0);
                set_wr($urandom_range(0, 1) == 1, int'($urandom_range(0, N + 15)), int'($urandom_range(0, 7)));
                step();
            end
            for (int x = 0; x < H; x++) begin
                pre_de = 1;
                frame_start = (x == 0) && (line % V == 0);
                set_wr($urandom_range(0, 1) == 1, int'($urandom_range(0, N + 15)), int'($urandom_range(0, 7)));
                step();
            end
            frame_start = 0;
        end
        pre_de = 0; en = 1;
        set_wr(0, 0, 0);
        repeat (10) step();

        chk("pixels_outstanding", pq.size(), 0);
        chk("writes_outstanding", ew.size() + mq.size(), 0);
        running = 0;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port synchronous pixel RAM between VGA scan-out and a pixel-writer client. Scan-out reads always win during active video. Writer requests are buffered in a 4-entry FIFO and drained into the RAM during blanking. The block sits between the 40 MHz VGA timing generator (which supplies frame_start/pre_de) and the colour outputs (rgb_out expands to Red/Green/Blue as today).

Parameters:
H_ACTIVE, 800, visible pixels per line
V_ACTIVE, 600, visible lines per frame
ADDR_W, 19, RAM address width (must hold H_ACTIVE*V_ACTIVE-1)
PIX_W, 3, pixel width (R,G,B bits)

Ports:
clk  in  1  pixel clock (40 MHz)
rst  in  1  synchronous reset, active-high
en  in  1  display enable; 0 forces black output, RAM freed for writes
frame_start  in  1  one-cycle pulse from timing gen at start of frame
pre_de  in  1  display-enable, leading visible pixel by 2 cycles
wr_valid  in  1  writer request
wr_ready  out  1  writer may transfer (FIFO not full)
wr_addr  in  ADDR_W  linear pixel address (y*H_ACTIVE+x)
wr_data  in  PIX_W  pixel value
wr_drop  out  1  one-cycle pulse: accepted write was out of range and discarded
fifo_level  out  3  current FIFO occupancy 0..4
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  PIX_W  RAM write data
mem_rdata  in  PIX_W  RAM read data, valid one cycle after address
rgb_out  out  PIX_W  pixel to DAC pins
de_out  out  1  rgb_out is a visible pixel

Behaviour:
- Reset (rst=1 at edge): rd_addr=0, FIFO emptied (contents discarded, even mid-frame), rgb_out=0, de_out=0, wr_drop=0, fifo_level=0, pipeline regs=0. While rst=1, mem_we=0 (combinational force) and wr_ready=0.
- Per-cycle state (combinational from current inputs/regs):
  - SCAN: pre_de=1 and en=1. mem_addr=rd_addr, mem_we=0. No drain.
  - DRAIN: otherwise, FIFO non-empty. mem_addr=head.addr, mem_wdata=head.data, mem_we=1, pop at edge.
  - IDLE: otherwise. mem_we=0, mem_addr=rd_addr.
- rd_addr:
  - frame_start=1 → rd_addr loads 0. If pre_de=1 in the same cycle, the read uses address 0 and rd_addr becomes 1.
  - Else, each SCAN cycle: rd_addr+1, wrapping from H_ACTIVE*V_ACTIVE-1 to 0.
  - rd_addr holds in non-SCAN cycles.
- Read pipeline, latency 2:
  - SCAN at cycle N → de_q=1 at N+1.
  - At edge ending N+1: rgb_out<=de_q?mem_rdata:0 and de_out<=de_q.
  - Visible at N+2, aligned with the pixel slot announced by pre_de.
  - en=0 → rgb_out and de_out registered 0.
- Writer handshake:
  - Transfer when wr_valid&wr_ready. wr_ready = (fifo_level<4) & ~rst, from registered level; no full-bypass.
  - wr_addr ≥ H_ACTIVE*V_ACTIVE: transfer is accepted but not pushed; wr_drop=1 next cycle; level unchanged.
  - Push and pop in the same cycle → level unchanged. The FIFO wraps internally (2-bit pointers + level).
  - Writes complete in FIFO order.
  - A write to the address currently being scanned lands only in blanking, so no tearing inside a scan cycle.
- Starvation: the writer is stalled for the whole active line. FIFO depth 4 is sufficient because each line's blanking far exceeds 4 cycles.
- fifo_level is registered; it reflects pushes/pops at the prior edge.

Test Plan:
- Reset mid-scan with 3 FIFO entries → next cycle fifo_level=0, rgb_out=0, de_out=0, mem_we=0; rd_addr restarts at 0 on pre_de.
- Preload RAM addr0..3 = 1,2,3,4; pulse frame_start with pre_de high 4 cycles from cycle 10 → mem_addr 0,1,2,3 at cycles 10–13; rgb_out 1,2,3,4 with de_out=1 at cycles 12–15; then 0.
- pre_de=1 for 20 cycles; writer pushes 6 writes → wr_ready drops after 4; mem_we=0 throughout. When pre_de falls, 4 RAM writes occur on consecutive cycles in order, then the remaining 2 are accepted.
- Simultaneous push and pop at fifo_level=2 → fifo_level stays 2; the popped entry is written to the RAM.
- wr_addr=480000 (=800*600) accepted → wr_drop=1 for one cycle; fifo_level unchanged; no mem_we.
- rd_addr at 479999 with pre_de=1 and no frame_start → next read address 0. Then en=0 with pre_de=1 and 2 queued writes → writes drained immediately, rgb_out=0.
